// File: rtl/bf_loop_ctrl.sv
// Loop sequencer: resolves [ and ] with a return stack (push/pop) and a nest-counting skip scanner.
// Optional fault handling (overflow/underflow -> sticky ERR) is enabled with `define BF_LOOP_ERR_EN.
module bf_loop_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ix_valid,
  input  logic                         ix_open,
  input  logic                         ix_close,
  input  logic [ADDR_W-1:0]            ix_pc,
  input  logic                         cell_zero,
  output logic                         ix_ready,
  output logic                         scan,
  output logic                         pc_load,
  output logic [ADDR_W-1:0]            pc_target,
  output logic [$clog2(STACK_DEPTH):0] depth,
  output logic                         err
);
  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int DEP_W = $clog2(STACK_DEPTH) + 1;
  localparam logic [DEP_W-1:0] FULL = DEP_W'(STACK_DEPTH);

  typedef enum logic [1:0] {RUN, SKIP, ERR} state_t;

  state_t            state_q;
  logic              ready_q, scan_q, pc_load_q, err_q;
  logic [ADDR_W-1:0] pc_target_q, nest_q;
  logic [DEP_W-1:0]  depth_q;
  logic [PTR_W-1:0]  wp_q;
  logic [ADDR_W-1:0] stk_q [STACK_DEPTH];

  logic              acc_d, open_d, close_d;
  logic              push_d, pop_d, redir_d, fault_d;
  logic [ADDR_W-1:0] top_d;

  assign top_d = stk_q[wp_q - 1'b1];

  always_comb begin
    acc_d   = ix_valid & ready_q;
    open_d  = acc_d & ix_open;
    close_d = acc_d & ix_close & ~ix_open;
    push_d  = 1'b0;
    pop_d   = 1'b0;
    redir_d = 1'b0;
    fault_d = 1'b0;
    if (state_q == RUN) begin
      if (open_d && !cell_zero) begin
        if (depth_q == FULL) begin
`ifdef BF_LOOP_ERR_EN
          fault_d = 1'b1;
`else
          // Circular stack: the write pointer has wrapped onto the oldest entry.
          push_d = 1'b1;
`endif
        end else begin
          push_d = 1'b1;
        end
      end
      if (close_d) begin
        if (depth_q == '0) begin
`ifdef BF_LOOP_ERR_EN
          fault_d = 1'b1;
`endif
        end else if (cell_zero) begin
          pop_d = 1'b1;
        end else begin
          redir_d = 1'b1;
        end
      end
    end
  end

  // Return-stack storage: data only, no reset.
  always_ff @(posedge clk) begin
    if (push_d) stk_q[wp_q] <= ix_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      ready_q     <= 1'b1;
      scan_q      <= 1'b0;
      pc_load_q   <= 1'b0;
      pc_target_q <= '0;
      depth_q     <= '0;
      wp_q        <= '0;
      nest_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      pc_load_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (open_d && cell_zero) begin
            state_q <= SKIP;
            scan_q  <= 1'b1;
            nest_q  <= ADDR_W'(1);
          end
          if (push_d) begin
            wp_q <= wp_q + 1'b1;
            if (depth_q != FULL) depth_q <= depth_q + 1'b1;
          end
          if (pop_d) begin
            wp_q    <= wp_q - 1'b1;
            depth_q <= depth_q - 1'b1;
          end
          if (redir_d) begin
            pc_load_q   <= 1'b1;
            pc_target_q <= top_d + 1'b1;
          end
          if (fault_d) begin
            state_q <= ERR;
            err_q   <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        SKIP: begin
          if (open_d) begin
            if (nest_q != '1) nest_q <= nest_q + 1'b1;
          end else if (close_d) begin
            nest_q <= nest_q - 1'b1;
            if (nest_q == ADDR_W'(1)) begin
              state_q <= RUN;
              scan_q  <= 1'b0;
            end
          end
        end
        default: begin
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ix_ready  = ready_q;
  assign scan      = scan_q;
  assign pc_load   = pc_load_q;
  assign pc_target = pc_target_q;
  assign depth     = depth_q;
  assign err       = err_q;
endmodule

// File: tb/tb_bf_loop_ctrl.sv
// Bench for bf_loop_ctrl: queue-based loop model checked every cycle, plus directed literal checks.
module tb_bf_loop_ctrl;
  localparam int AW = 16;
  localparam int SD = 16;

  logic          clk = 1'b0;
  logic          rst, ix_valid, ix_open, ix_close, cell_zero;
  logic [AW-1:0] ix_pc;
  logic          ix_ready, scan, pc_load, err;
  logic [AW-1:0] pc_target;
  logic [4:0]    depth;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model state: 0 = RUN, 1 = SKIP, 2 = ERR
  logic [AW-1:0] m_stk[$];
  int            m_mode = 0;
  logic [AW-1:0] m_nest = '0;
  logic          m_load = 1'b0;
  logic [AW-1:0] m_target = '0;
  logic          m_err = 1'b0;

  bf_loop_ctrl #(.ADDR_W(AW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .rst(rst), .ix_valid(ix_valid), .ix_open(ix_open), .ix_close(ix_close),
    .ix_pc(ix_pc), .cell_zero(cell_zero), .ix_ready(ix_ready), .scan(scan),
    .pc_load(pc_load), .pc_target(pc_target), .depth(depth), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model, updated on every rising edge from the presented inputs.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_stk.delete();
      m_mode = 0;
      m_nest = '0;
      m_load = 1'b0;
      m_err  = 1'b0;
    end else begin
      m_load = 1'b0;
      if (ix_valid && m_mode == 1) begin
        if (ix_open) begin
          if (m_nest != 16'hFFFF) m_nest = m_nest + 16'd1;
        end else if (ix_close) begin
          m_nest = m_nest - 16'd1;
          if (m_nest == 0) m_mode = 0;
        end
      end else if (ix_valid && m_mode == 0) begin
        if (ix_open) begin
          if (cell_zero) begin
            m_mode = 1;
            m_nest = 16'd1;
          end else if (m_stk.size() == SD) begin
`ifdef BF_LOOP_ERR_EN
            m_mode = 2;
            m_err  = 1'b1;
`else
            void'(m_stk.pop_front());
            m_stk.push_back(ix_pc);
`endif
          end else begin
            m_stk.push_back(ix_pc);
          end
        end else if (ix_close) begin
          if (m_stk.size() == 0) begin
`ifdef BF_LOOP_ERR_EN
            m_mode = 2;
            m_err  = 1'b1;
`endif
          end else if (cell_zero) begin
            void'(m_stk.pop_back());
          end else begin
            m_load   = 1'b1;
            m_target = m_stk[$] + 16'd1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("scan", {31'd0, scan}, {31'd0, m_mode == 1});
      check("pc_load", {31'd0, pc_load}, {31'd0, m_load});
      if (m_load) check("pc_target", {16'd0, pc_target}, {16'd0, m_target});
      check("depth", {27'd0, depth}, m_stk.size());
      check("err", {31'd0, err}, {31'd0, m_err});
      check("ix_ready", {31'd0, ix_ready}, {31'd0, m_mode != 2});
    end
  end

  // Present one instruction for one cycle; returns at the negedge after it was sampled.
  task automatic drive(input logic o, input logic c, input logic [AW-1:0] pc, input logic cz);
    ix_valid = 1'b1; ix_open = o; ix_close = c; ix_pc = pc; cell_zero = cz;
    @(negedge clk);
    ix_valid = 1'b0; ix_open = 1'b0; ix_close = 1'b0; cell_zero = 1'b0;
  endtask

  task automatic idle();
    ix_valid = 1'b0; ix_open = 1'b0; ix_close = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ix_valid = 1'b0; ix_open = 1'b0; ix_close = 1'b0; ix_pc = '0; cell_zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_scan", {31'd0, scan}, 32'd0);
    check("rst_pc_load", {31'd0, pc_load}, 32'd0);
    check("rst_pc_target", {16'd0, pc_target}, 32'd0);
    check("rst_depth", {27'd0, depth}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ready", {31'd0, ix_ready}, 32'd1);
    rst = 1'b0;

    // Simple loop taken once, then exited.
    drive(1'b1, 1'b0, 16'h0010, 1'b0);
    check("t1_depth", {27'd0, depth}, 32'd1);
    drive(1'b0, 1'b1, 16'h0020, 1'b0);
    check("t1_load", {31'd0, pc_load}, 32'd1);
    check("t1_target", {16'd0, pc_target}, 32'h0011);
    check("t1_depth2", {27'd0, depth}, 32'd1);
    idle();
    check("t1_load_pulse", {31'd0, pc_load}, 32'd0);
    drive(1'b0, 1'b1, 16'h0020, 1'b1);
    check("t2_noload", {31'd0, pc_load}, 32'd0);
    check("t2_depth", {27'd0, depth}, 32'd0);

    // Skip a nested body: [ [ + ] - ]
    drive(1'b1, 1'b0, 16'h0005, 1'b1);
    check("t3_scan_up", {31'd0, scan}, 32'd1);
    drive(1'b1, 1'b0, 16'h0006, 1'b0);
    drive(1'b0, 1'b0, 16'h0007, 1'b0);
    drive(1'b0, 1'b1, 16'h0008, 1'b0);
    check("t3_scan_mid", {31'd0, scan}, 32'd1);
    drive(1'b0, 1'b0, 16'h0009, 1'b0);
    drive(1'b0, 1'b1, 16'h000A, 1'b0);
    check("t3_scan_down", {31'd0, scan}, 32'd0);
    check("t3_depth", {27'd0, depth}, 32'd0);

    // Open and close together: open wins (push), then pop it.
    drive(1'b1, 1'b1, 16'h0030, 1'b0);
    check("both_push", {27'd0, depth}, 32'd1);
    drive(1'b0, 1'b1, 16'h0031, 1'b1);

    // Address wrap: top 0xFFFF redirects to 0x0000.
    drive(1'b1, 1'b0, 16'hFFFF, 1'b0);
    drive(1'b0, 1'b1, 16'h0040, 1'b0);
    check("wrap_load", {31'd0, pc_load}, 32'd1);
    check("wrap_target", {16'd0, pc_target}, 32'h0000);
    idle();
    drive(1'b0, 1'b1, 16'h0040, 1'b1);

    // Seventeen pushes into a sixteen-deep stack.
    for (int i = 0; i < 17; i++) drive(1'b1, 1'b0, 16'h0100 + 16'(i), 1'b0);
`ifdef BF_LOOP_ERR_EN
    check("ovf_err", {31'd0, err}, 32'd1);
    check("ovf_ready", {31'd0, ix_ready}, 32'd0);
    pulse_rst();
`else
    check("ovf_depth", {27'd0, depth}, 32'd16);
    check("ovf_err", {31'd0, err}, 32'd0);
    drive(1'b0, 1'b1, 16'h0200, 1'b0);
    check("ovf_target", {16'd0, pc_target}, 32'h0111);
    idle();
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 16'h0200, 1'b1);
    check("ovf_drained", {27'd0, depth}, 32'd0);
    drive(1'b0, 1'b1, 16'h0200, 1'b0);
    check("ovf_lost", {31'd0, pc_load}, 32'd0);
`endif

    // Underflow on an empty stack.
    drive(1'b0, 1'b1, 16'h0300, 1'b0);
`ifdef BF_LOOP_ERR_EN
    check("unf_err", {31'd0, err}, 32'd1);
    pulse_rst();
`else
    check("unf_noload", {31'd0, pc_load}, 32'd0);
    check("unf_run", {31'd0, scan}, 32'd0);
    check("unf_err", {31'd0, err}, 32'd0);
`endif

    // Reset during SKIP with nest = 3.
    drive(1'b1, 1'b0, 16'h0400, 1'b1);
    drive(1'b1, 1'b0, 16'h0401, 1'b0);
    drive(1'b1, 1'b0, 16'h0402, 1'b0);
    pulse_rst();
    check("rs_scan", {31'd0, scan}, 32'd0);
    check("rs_depth", {27'd0, depth}, 32'd0);
    check("rs_err", {31'd0, err}, 32'd0);
    drive(1'b1, 1'b0, 16'h0500, 1'b0);
    check("rs_push", {27'd0, depth}, 32'd1);

    // Reset coinciding with a redirecting ]: the pulse is cancelled.
    rst = 1'b1;
    drive(1'b0, 1'b1, 16'h0501, 1'b0);
    rst = 1'b0;
    check("rr_cancel", {31'd0, pc_load}, 32'd0);
    check("rr_depth", {27'd0, depth}, 32'd0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bf_loop_ctrl.md
# bf_loop_ctrl

Loop sequencer for the bfX core. It sits between the instruction decoder and the program counter. It resolves `[` and `]` using a hardware return stack and a forward-skip scanner, and tells the PC when to redirect. All bracket matching is done here, so the core's fetch path stays strictly sequential apart from `pc_load` redirects.

## Interface
- `ADDR_W`, default 16: program address width (matches `pc`).
- `STACK_DEPTH`, default 16: maximum nesting of live loops (power of two).
- `clk`, input, 1: core clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `ix_valid`, input, 1: decoded instruction present this cycle.
- `ix_open`, input, 1: instruction is `[`.
- `ix_close`, input, 1: instruction is `]`.
- `ix_pc`, input, ADDR_W: address of the presented instruction.
- `cell_zero`, input, 1: current data cell equals 0, valid with `ix_valid`.
- `ix_ready`, output, 1: controller accepts the instruction; transfer occurs on `ix_valid & ix_ready`.
- `scan`, output, 1: skip mode; the core must not execute non-bracket instructions.
- `pc_load`, output, 1: one-cycle pulse; PC takes `pc_target`.
- `pc_target`, output, ADDR_W: redirect address.
- `depth`, output, $clog2(STACK_DEPTH)+1: live stack entries.
- `err`, output, 1: sticky fault (see Configuration).

## Operation
- States: RUN, SKIP, ERR. Reset enters RUN.
- Accepted instruction (`ix_valid & ix_ready`) with neither bracket set: no action in any state.
- If `ix_open` and `ix_close` are both set, `ix_open` wins.

RUN:
- `[` with `cell_zero=1`: go to SKIP, set `nest=1`. No push.
- `[` with `cell_zero=0`: push `ix_pc`.
- `]` with `cell_zero=1`: pop. No redirect.
- `]` with `cell_zero=0`: no pop. Pulse `pc_load` with `pc_target = top + 1`, the instruction after the matching `[`. The stack is unchanged.
- `]` with an empty stack: underflow.
- Push with `depth == STACK_DEPTH`: overflow.

SKIP:
- `[` increments `nest`.
- `]` decrements `nest`. When it reaches 0, return to RUN.
- The stack is untouched throughout.
- `nest` is ADDR_W wide and saturates at all-ones; it never wraps.

ERR:
- `ix_ready=0`, `pc_load=0`. Held until `rst`.

General rules:
- `ix_ready = 1` in RUN and SKIP. The controller never stalls on a legal stream.
- Address arithmetic is modulo 2^ADDR_W: a top entry of 16'hFFFF gives `pc_target` 16'h0000.

## Timing
- All outputs are registered.
- Reset values: `scan=0`, `pc_load=0`, `pc_target=0`, `depth=0`, `err=0`, `nest=0`; stack contents are don't-care.
- `pc_load`/`pc_target` are asserted the cycle after the `]` is accepted, for exactly 1 cycle. The core discards any instruction presented during the `pc_load` cycle.
- `scan` rises the cycle after the skipping `[` is accepted. It falls the cycle after the matching `]` is accepted.
- `depth` reflects a push or pop 1 cycle after acceptance.
- Back-to-back brackets are accepted every cycle; the stack has single-cycle push/pop with no bypass hazard.
- `rst` asserted mid-SKIP or mid-redirect: the next cycle is RUN with reset values. Any pending `pc_load` is cancelled.

## Configuration
- `BF_LOOP_ERR_EN` defined:
  - Overflow or underflow sets `err` and enters ERR.
  - In SKIP, a `]` that would take `nest` below 0 is impossible by construction.
- `BF_LOOP_ERR_EN` undefined:
  - There is no ERR state and `err` is tied to 0.
  - Overflow overwrites the oldest entry (circular stack); `depth` stays at `STACK_DEPTH`.
  - Underflow `]` is a no-op: no pop, no redirect.

## Test plan
- Reset, then `[`@0x0010 with `cell_zero=0`: `depth=1`. Then `]`@0x0020 with `cell_zero=0`: 1 cycle later `pc_load=1`, `pc_target=0x0011`, `depth=1`.
- Same loop, `]` with `cell_zero=1`: no `pc_load`, `depth=0`.
- `[`@0x0005 with `cell_zero=1`, then stream `[ + ] - ]`: `scan=1` from the cycle after the `[` until the cycle after the final `]`. `depth` stays 0 and no `pc_load` occurs.
- Push 17 `[` with `cell_zero=0` at `STACK_DEPTH=16`:
  - With `BF_LOOP_ERR_EN`: `err=1`, `ix_ready=0`.
  - Without it: `depth=16`, and the oldest entry is lost (the 17th `]` redirect is absent / underflow no-op).
- `]` on an empty stack with `cell_zero=0`:
  - With `BF_LOOP_ERR_EN`: `err=1`.
  - Without it: no `pc_load`, state RUN.
- `rst` pulsed during SKIP with `nest=3`: the next cycle shows `scan=0`, `depth=0`, `err=0`, and a following `[` with `cell_zero=0` pushes normally.
